// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit: default geometry,
// the per-cycle action encoding and its fixed-priority decoder.
package pc_pkg;

  localparam int unsigned DefaultWidth       = 16;
  localparam int unsigned DefaultResetVector = 32'h0000_0004;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_CALL,
    ACT_LOAD,
    ACT_INCR
  } action_e;

  // Exactly one action per cycle; ret > call > load > incr, stall wins over all.
  function automatic action_e decode_action(input logic en, input logic ret, input logic call,
                                            input logic load, input logic incr);
    if (!en)       return ACT_HOLD;
    else if (ret)  return ACT_RET;
    else if (call) return ACT_CALL;
    else if (load) return ACT_LOAD;
    else if (incr) return ACT_INCR;
    else           return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack: a small LIFO that silently ignores push-when-full and
// pop-when-empty; the owner decides how to flag those cases.
module ras_lifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic [WIDTH-1:0]         top_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CntW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign wr_ptr     = count_q[PtrW-1:0];
  assign rd_ptr     = wr_ptr - PtrW'(1);
  assign top_data_o = mem_q[rd_ptr];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only count decides which entries are live.
  always_ff @(posedge clock) begin
    if (resetn && do_push) begin
      mem_q[wr_ptr] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with jump/step/call/return and a hardware return-address
// stack; error flags are sticky until reset.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = DefaultWidth,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DefaultResetVector),
  parameter int unsigned       STEP         = 1,
  parameter int unsigned       DEPTH        = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             incr_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] load_addr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             stack_full_o,
  output logic             stack_empty_o,
  output logic             overflow_err_o,
  output logic             underflow_err_o
);

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);
  localparam int unsigned      CntW  = $clog2(DEPTH) + 1;

  action_e          action;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full, ras_empty;
  logic [CntW-1:0]  ras_count;

  assign action = decode_action(en_i, ret_i, call_i, load_i, incr_i);

  ras_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clock       (clock),
    .resetn      (resetn),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q + StepW),
    .top_data_o  (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .count_o     (ras_count)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (action)
      ACT_RET: begin
        if (!ras_empty) begin
          pc_d = ras_top;
          pop  = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      ACT_CALL: begin
        // The jump happens even when the return address cannot be saved.
        pc_d = load_addr_i;
        if (!ras_full) begin
          push = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      ACT_LOAD: pc_d = load_addr_i;
      ACT_INCR: pc_d = pc_q + StepW;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_o            = pc_q;
  assign stack_full_o    = (ras_count == CntW'(DEPTH));
  assign stack_empty_o   = (ras_count == '0);
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: a behavioural model queues the expected
// state for every driven cycle; each scenario pops and compares after the edge.
module tb_pc_unit_ras;

  typedef struct packed {
    logic [15:0] pc;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } obs_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        en_i = 1'b0, load_i = 1'b0, incr_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
  logic [15:0] load_addr_i = '0;
  logic [15:0] pc_o;
  logic        stack_full_o, stack_empty_o, overflow_err_o, underflow_err_o;

  int checks = 0;
  int failures = 0;

  obs_t        sb[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc = 16'h0004;
  logic        m_ovf = 1'b0, m_unf = 1'b0;

  pc_unit_ras dut (
    .clock           (clock),
    .resetn          (resetn),
    .en_i            (en_i),
    .load_i          (load_i),
    .incr_i          (incr_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .load_addr_i     (load_addr_i),
    .pc_o            (pc_o),
    .stack_full_o    (stack_full_o),
    .stack_empty_o   (stack_empty_o),
    .overflow_err_o  (overflow_err_o),
    .underflow_err_o (underflow_err_o)
  );

  always #5 clock = ~clock;

  function automatic obs_t observed();
    return '{pc_o, stack_full_o, stack_empty_o, overflow_err_o, underflow_err_o};
  endfunction

  function automatic obs_t model_state();
    return '{m_pc, m_stack.size() == 8, m_stack.size() == 0, m_ovf, m_unf};
  endfunction

  task automatic drive(input logic e, input logic r, input logic c, input logic l,
                       input logic i, input logic [15:0] a);
    en_i = e; ret_i = r; call_i = c; load_i = l; incr_i = i; load_addr_i = a;
    if (e) begin
      if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_unf = 1'b1;
      end else if (c) begin
        if (m_stack.size() < 8) m_stack.push_back(m_pc + 16'd1);
        else m_ovf = 1'b1;
        m_pc = a;
      end else if (l) begin
        m_pc = a;
      end else if (i) begin
        m_pc = m_pc + 16'd1;
      end
    end
    sb.push_back(model_state());
    @(posedge clock);
    #1;
    en_i = 1'b0; ret_i = 1'b0; call_i = 1'b0; load_i = 1'b0; incr_i = 1'b0;
  endtask

  task automatic drive_reset(input logic c, input logic [15:0] a);
    resetn = 1'b0; en_i = 1'b1; call_i = c; load_addr_i = a;
    m_pc = 16'h0004; m_ovf = 1'b0; m_unf = 1'b0; m_stack.delete();
    sb.push_back(model_state());
    @(posedge clock);
    #1;
    resetn = 1'b1; en_i = 1'b0; call_i = 1'b0;
  endtask

  task automatic test_reset;
    obs_t exp;
    logic [15:0] want_pc[3] = '{16'h0005, 16'h0006, 16'h0007};
    drive_reset(1'b0, 16'h0000);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || observed() !== obs_t'({16'h0004, 4'b0100})) begin
      failures++;
      $display("FAIL reset: got %h want %h", observed(), exp);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp || pc_o !== want_pc[k]) begin
        failures++;
        $display("FAIL incr%0d: got %h want %h (pc %h)", k, observed(), exp, want_pc[k]);
      end
    end
  endtask

  task automatic test_wrap_stall;
    obs_t exp;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL load_ffff: got %h want %h", observed(), exp);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || pc_o !== 16'h0000) begin
      failures++;
      $display("FAIL wrap: got %h want %h", observed(), exp);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp || pc_o !== 16'h0000) begin
        failures++;
        $display("FAIL stall%0d: got %h want %h", k, observed(), exp);
      end
    end
  endtask

  task automatic test_call_ret;
    obs_t exp;
    logic [15:0] want_pc[5] = '{16'h0100, 16'h0101, 16'h0200, 16'h0102, 16'h0011};
    logic [3:0]  ops[5] = '{4'b0100, 4'b0001, 4'b0100, 4'b1000, 4'b1000}; // {ret,call,load,incr}
    logic [15:0] addrs[5] = '{16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0000};
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
    void'(sb.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ops[k][3], ops[k][2], ops[k][1], ops[k][0], addrs[k]);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp || pc_o !== want_pc[k]) begin
        failures++;
        $display("FAIL nest%0d: got %h want %h (pc %h)", k, observed(), exp, want_pc[k]);
      end
    end
    checks++;
    if (stack_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL nest_empty: got %b want 1", stack_empty_o);
    end
  endtask

  task automatic test_overflow;
    obs_t exp;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0300);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL fill%0d: got %h want %h", k, observed(), exp);
      end
    end
    checks++;
    if (stack_full_o !== 1'b1) begin
      failures++;
      $display("FAIL full: got %b want 1", stack_full_o);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0400);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || pc_o !== 16'h0400 || overflow_err_o !== 1'b1) begin
      failures++;
      $display("FAIL overflow: got %h want %h", observed(), exp);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp || pc_o !== (k == 7 ? 16'h0012 : 16'h0301)) begin
        failures++;
        $display("FAIL drain%0d: got %h want %h", k, observed(), exp);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || pc_o !== 16'h0012 || underflow_err_o !== 1'b1) begin
      failures++;
      $display("FAIL underflow: got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_reset_mid;
    obs_t exp;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0700 + 16'(k));
      void'(sb.pop_front());
    end
    drive_reset(1'b1, 16'h0777);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || observed() !== obs_t'({16'h0004, 4'b0100})) begin
      failures++;
      $display("FAIL reset_mid: got %h want %h", observed(), exp);
    end
    // A pop right after reset must underflow: nothing was pushed by the reset-cycle call.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || observed() !== obs_t'({16'h0004, 4'b0101})) begin
      failures++;
      $display("FAIL reset_nopush: got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_priority;
    obs_t exp;
    drive_reset(1'b0, 16'h0000);
    void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h004F);
    void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0123);
    void'(sb.pop_front());
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0999);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || observed() !== obs_t'({16'h0050, 4'b0100})) begin
      failures++;
      $display("FAIL priority: got %h want %h", observed(), exp);
    end
    // call+ret on an empty stack: underflow only, no jump, no push.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0AAA);
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp || observed() !== obs_t'({16'h0050, 4'b0101})) begin
      failures++;
      $display("FAIL callret_empty: got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_back_to_back;
    obs_t exp;
    logic [4:0] r;
    for (int k = 0; k < 300; k++) begin
      r = 5'($urandom);
      drive($urandom_range(0, 7) != 0, r[4] & r[3], r[2], r[1], r[0], 16'($urandom));
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL random%0d: got %h want %h", k, observed(), exp);
      end
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_wrap_stall();
    test_call_ret();
    test_overflow();
    test_reset_mid();
    test_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit for the multicycle processor datapath; successor to the fixed 16-bit PC register.
- Adds a configurable width, reset vector and increment step, and an explicit stall enable.
- Adds a hardware return-address stack (RAS) for call/return, with full/empty status and sticky error flags.
- Sits between the control FSM (load/incr/call/ret strobes) and the memory address mux (pc output).

Parameters:
- WIDTH, 16, bit width of the PC, load_addr and stack entries.
- RESET_VECTOR, 16'h0004, PC value after reset; must fit in WIDTH.
- STEP, 1, increment amount applied on incr and used for the call return address.
- DEPTH, 8, number of RAS entries; power of two, minimum 2.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- en  in  1  global advance enable; when low, all state holds and all strobes are ignored.
- load  in  1  jump: pc <= load_addr.
- incr  in  1  sequential advance: pc <= pc + STEP.
- call  in  1  push pc + STEP onto the RAS; pc <= load_addr.
- ret  in  1  pop the RAS top into pc.
- load_addr  in  WIDTH  jump/call target.
- pc  out  WIDTH  current program counter (registered).
- stack_full  out  1  RAS holds DEPTH entries (combinational from count).
- stack_empty  out  1  RAS holds 0 entries (combinational from count).
- overflow_err  out  1  sticky: a call was attempted with the RAS full.
- underflow_err  out  1  sticky: a ret was attempted with the RAS empty.

Behaviour:
- All state updates on the rising edge of clock; no asynchronous paths.
- Reset (resetn=0 at an edge, regardless of en or strobes):
  - pc = RESET_VECTOR; RAS count = 0.
  - stack_empty = 1, stack_full = 0; overflow_err = 0, underflow_err = 0.
  - RAS storage contents are don't-care.
  - A reset mid-sequence discards any pending state immediately.
- en=0: pc, RAS and flags hold; strobes are ignored (stall).
- With en=1, exactly one action per cycle, in fixed priority ret > call > load > incr.
- ret:
  - If count>0: pc <= stack[count-1], count decrements.
  - If count==0: pc holds, underflow_err <= 1.
- call:
  - If count<DEPTH: stack[count] <= pc + STEP (mod 2^WIDTH), count increments, pc <= load_addr.
  - If count==DEPTH: jump still occurs (pc <= load_addr), push is dropped, count unchanged, overflow_err <= 1.
- load: pc <= load_addr; RAS unchanged.
- incr: pc <= pc + STEP, truncated to WIDTH (wrap-around, no flag).
- No strobe active: pc holds.
- Simultaneous events:
  - The lower-priority strobe is ignored entirely; it is not queued.
  - Example: call+ret with count==0 gives a ret underflow (pc holds), no push, no jump.
- Latency: a new pc is visible one cycle after the strobe edge; stack_full/stack_empty track count in the same cycle as pc.
- Error flags: sticky until reset; no other clear mechanism.
- Count register width is clog2(DEPTH)+1 so that count==DEPTH is representable.

Decomposition:
- Shared package pc_pkg: WIDTH default, RESET_VECTOR default, an action enum (ACT_HOLD, ACT_RET, ACT_CALL, ACT_LOAD, ACT_INCR) and a priority-decode function returning the action from {en, ret, call, load, incr}.
- Sub-module ras_lifo (params WIDTH, DEPTH):
  - Inputs: push, pop, push_data.
  - Outputs: top_data, full, empty, count.
  - Pushes when full and pops when empty are ignored inside the LIFO; pc_unit_ras generates the error flags.
- Top level: action decode, pc register, sticky flags.

Test Plan:
- Reset/incr: hold resetn=0 one cycle, then incr for 3 cycles -> pc = 4, 5, 6, 7; stack_empty=1; both error flags 0.
- Wrap and stall: WIDTH=16, load 16'hFFFF, then incr -> pc=16'h0000. With en=0, assert incr for 2 cycles -> pc stays 16'h0000.
- Call/ret nesting, DEPTH=8: from pc=0x0010, call 0x0100; incr; call 0x0200; ret; ret -> pc sequence 0x0100, 0x0101, 0x0200, 0x0102, 0x0011; stack_empty=1 at end.
- Overflow: 8 calls to 0x0300 -> stack_full=1. A 9th call to 0x0400 -> pc=0x0400, overflow_err=1, count stays 8. Then 8 rets all succeed; a 9th ret -> pc holds, underflow_err=1.
- Priority: with count=1 and top=0x0050, assert ret+call+load+incr with load_addr=0x0999 -> pc=0x0050, count=0, nothing pushed.
- Reset mid-operation: after 3 calls with overflow_err=1, drive resetn=0 together with call -> pc=0x0004, count=0, both flags 0, no push.
